gpio_ctrl: RTL and testbench
============================

GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of GPIO pins, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth, legal range 2..3.
REQ-003 SHALL have parameter ADDR_LSB, default 2, lowest Address bit of the register offset field.
REQ-004 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Address  input  32  CPU data address; offset = Address[ADDR_LSB+2:ADDR_LSB].
REQ-007 SHALL have port DataIn  input  32  write data from CPU.
REQ-008 SHALL have port DataOut  output  32  read data to CPU.
REQ-009 SHALL have port Select  input  1  block selected by address decoder.
REQ-010 SHALL have port WriteEn  input  1  CPU store strobe.
REQ-011 SHALL have port GPIO_In  input  WIDTH  asynchronous pin inputs.
REQ-012 SHALL have port GPIO_Out  output  WIDTH  pin output values.
REQ-013 SHALL have port GPIO_OE  output  WIDTH  pin output enables, 1 = drive.
REQ-014 SHALL have port irq  output  1  interrupt request, active-high.

Function
REQ-015 Register map by offset SHALL be: 0 OUT (rw), 1 IN (ro), 2 DIR (rw), 3 IRQ_EN (rw), 4 IRQ_STAT (read, write-1-to-clear), 5 POL (rw; 0 rising, 1 falling), 6 OUT_SET (wo), 7 OUT_CLR (wo).
REQ-016 Writes SHALL occur on rising clk when Select=1 and WriteEn=1, using DataIn[WIDTH-1:0]; DataIn upper bits ignored.
REQ-017 OUT_SET write SHALL do OUT |= DataIn; OUT_CLR write SHALL do OUT &= ~DataIn; both read as 0.
REQ-018 Writes to IN SHALL be ignored.
REQ-019 DataOut SHALL be combinational: selected register zero-extended to 32 bits when Select=1, all zeros when Select=0.
REQ-020 GPIO_Out SHALL equal OUT and GPIO_OE SHALL equal DIR, registered, no extra latency beyond the write edge.
REQ-021 Each GPIO_In bit SHALL pass through a SYNC_STAGES flop chain; IN SHALL read the chain output regardless of DIR.
REQ-022 A pin change SHALL be visible in IN exactly SYNC_STAGES rising edges after it is sampled.
REQ-023 An edge detector SHALL hold one previous-synchronized flop per bit; a qualifying edge (per POL) on an IRQ_EN=1 bit SHALL set its IRQ_STAT bit one clock after it appears in IN.
REQ-024 IRQ_STAT bits SHALL be sticky until cleared by writing 1 to that bit at offset 4.
REQ-025 Simultaneous set event and write-1-clear on the same bit SHALL leave the bit set.
REQ-026 irq SHALL equal OR of (IRQ_STAT & IRQ_EN), combinational from registers.
REQ-027 Clearing an IRQ_EN bit SHALL mask irq but SHALL NOT clear its IRQ_STAT bit.
REQ-028 A POL change SHALL NOT itself generate an event; only synchronized pin transitions do.
REQ-029 Reads SHALL have no side effects.

Reset
REQ-030 rst low SHALL asynchronously clear OUT, DIR, IRQ_EN, IRQ_STAT, POL, the synchronizer chain and edge flops to 0.
REQ-031 During and after reset, GPIO_Out=0, GPIO_OE=0, irq=0; DataOut follows REQ-019.
REQ-032 Reset asserted mid-operation SHALL discard pending edges; no event SHALL be generated by reset release alone while IRQ_EN=0.

Structure
REQ-033 Register offset constants and the POL encoding SHALL live in a shared package gpio_pkg.
REQ-034 The per-bit synchronizer SHALL be a sub-module gpio_sync, parameterised by SYNC_STAGES, with the same clk/rst.

Verification (WIDTH=8, SYNC_STAGES=2, ADDR_LSB=2)
REQ-035 Reset: rst=0 with GPIO_In=8'hFF -> GPIO_Out=0, GPIO_OE=0, irq=0; after release, read offset 1 returns 8'hFF within 2 clocks.
REQ-036 Write 0xA5 to offset 0, 0xF0 to offset 2, then 0x03 to offset 6, 0x80 to offset 7 -> GPIO_Out=0x27, GPIO_OE=0xF0; reads of offsets 6 and 7 return 0.
REQ-037 IRQ_EN=0x01, POL=0, GPIO_In[0] 0->1 -> IRQ_STAT=0x01 and irq=1 exactly 3 clocks after sampling; write 0x01 to offset 4 -> irq=0.
REQ-038 POL=0x02, IRQ_EN=0x02, GPIO_In[1] 1->0 -> IRQ_STAT=0x02; GPIO_In[1] 0->1 -> no new event.
REQ-039 Edge reaching IRQ_STAT in the same cycle as a write-1-clear of that bit -> bit remains 1.
REQ-040 Pending IRQ_STAT=0x01, write IRQ_EN=0 -> irq=0, read offset 4 still returns 0x01; Select=0 -> DataOut=0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register-map offsets and edge-polarity encoding for the GPIO controller.
package gpio_pkg;

    typedef enum logic [2:0] {
        REG_OUT      = 3'd0,
        REG_IN       = 3'd1,
        REG_DIR      = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_STAT = 3'd4,
        REG_POL      = 3'd5,
        REG_OUT_SET  = 3'd6,
        REG_OUT_CLR  = 3'd7
    } gpio_reg_e;

    localparam logic POL_RISE = 1'b0;
    localparam logic POL_FALL = 1'b1;

    function automatic logic edge_hit(input logic cur, input logic prev, input logic pol);
        return (pol == POL_FALL) ? (prev & ~cur) : (cur & ~prev);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Single-bit flop-chain synchronizer for an asynchronous pin input.
module gpio_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block: output/direction registers, synchronized inputs,
// per-pin edge interrupts with sticky write-1-to-clear status.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_LSB    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Address,
    input  logic [31:0]      DataIn,
    output logic [31:0]      DataOut,
    input  logic             Select,
    input  logic             WriteEn,
    input  logic [WIDTH-1:0] GPIO_In,
    output logic [WIDTH-1:0] GPIO_Out,
    output logic [WIDTH-1:0] GPIO_OE,
    output logic             irq
);

    gpio_reg_e        reg_off;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] out_r, dir_r, en_r, stat_r, pol_r;
    logic [WIDTH-1:0] in_p0, in_p1;
    logic [WIDTH-1:0] evt, stat_clr, rd_val;
    logic             unused_bus_bits;

    assign reg_off         = gpio_reg_e'(Address[ADDR_LSB+2:ADDR_LSB]);
    assign wr_en           = Select & WriteEn;
    assign wdata           = DataIn[WIDTH-1:0];
    assign unused_bus_bits = ^{Address, DataIn};

    // Stage p0: synchronized pin levels
    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (GPIO_In[i]),
            .q   (in_p0[i])
        );
    end

    // Stage p1: previous synchronized level, compared against p0 for edges
    always_comb begin
        evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            evt[i] = edge_hit(in_p0[i], in_p1[i], pol_r[i]);
        end
    end

    assign stat_clr = (wr_en && reg_off == REG_IRQ_STAT) ? wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r  <= '0;
            dir_r  <= '0;
            en_r   <= '0;
            stat_r <= '0;
            pol_r  <= '0;
            in_p1  <= '0;
        end else begin
            in_p1  <= in_p0;
            // a new event wins over a simultaneous clear of the same bit
            stat_r <= (stat_r & ~stat_clr) | (evt & en_r);
            if (wr_en) begin
                case (reg_off)
                    REG_OUT:     out_r <= wdata;
                    REG_DIR:     dir_r <= wdata;
                    REG_IRQ_EN:  en_r  <= wdata;
                    REG_POL:     pol_r <= wdata;
                    REG_OUT_SET: out_r <= out_r | wdata;
                    REG_OUT_CLR: out_r <= out_r & ~wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (Select) begin
            case (reg_off)
                REG_OUT:      rd_val = out_r;
                REG_IN:       rd_val = in_p0;
                REG_DIR:      rd_val = dir_r;
                REG_IRQ_EN:   rd_val = en_r;
                REG_IRQ_STAT: rd_val = stat_r;
                REG_POL:      rd_val = pol_r;
                default:      rd_val = '0;
            endcase
        end
        DataOut               = '0;
        DataOut[WIDTH-1:0]    = rd_val;
    end

    assign GPIO_Out = out_r;
    assign GPIO_OE  = dir_r;
    assign irq      = |(stat_r & en_r);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: driver pushes expectations from a behavioural
// model, a negedge monitor pops and compares them against the DUT.
module tb_gpio_ctrl;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int ALSB  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address, DataIn, DataOut;
    logic        Select, WriteEn;
    logic [7:0]  GPIO_In, GPIO_Out, GPIO_OE;
    logic        irq;

    gpio_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .ADDR_LSB(ALSB)) dut (
        .clk      (clk),
        .rst      (rst),
        .Address  (Address),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .Select   (Select),
        .WriteEn  (WriteEn),
        .GPIO_In  (GPIO_In),
        .GPIO_Out (GPIO_Out),
        .GPIO_OE  (GPIO_OE),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: register contents plus a history of pin samples.
    logic [7:0] m_out, m_dir, m_en, m_stat, m_pol;
    logic [7:0] samp[$];

    // IN shows the pin sampled SYNC edges ago (counting the sampling edge).
    function automatic logic [7:0] model_in();
        return samp[samp.size() - SYNC];
    endfunction

    function automatic logic [7:0] model_prev();
        return samp[samp.size() - 1 - SYNC];
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] off);
        case (off)
            3'd0:    return {24'h0, m_out};
            3'd1:    return {24'h0, model_in()};
            3'd2:    return {24'h0, m_dir};
            3'd3:    return {24'h0, m_en};
            3'd4:    return {24'h0, m_stat};
            3'd5:    return {24'h0, m_pol};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_out = 8'h0; m_dir = 8'h0; m_en = 8'h0; m_stat = 8'h0; m_pol = 8'h0;
        samp.delete();
        repeat (SYNC + 1) samp.push_back(8'h00);
    endtask

    task automatic push(input int kind, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        logic [7:0] in_now, prev_now, evt, clr, d;
        push(1, {24'h0, m_out});
        push(2, {24'h0, m_dir});
        push(3, {31'h0, |(m_stat & m_en)});
        if (Select) push(0, model_rd(Address[4:2]));
        @(posedge clk);
        if (rst) begin
            in_now   = model_in();
            prev_now = model_prev();
            // qualifying transition: level changed and new level is not the POL level
            evt = (in_now ^ prev_now) & (in_now ^ m_pol) & m_en;
            clr = 8'h0;
            if (Select && WriteEn) begin
                d = DataIn[7:0];
                case (Address[4:2])
                    3'd0: m_out = d;
                    3'd2: m_dir = d;
                    3'd3: m_en  = d;
                    3'd4: clr   = d;
                    3'd5: m_pol = d;
                    3'd6: m_out = m_out | d;
                    3'd7: m_out = m_out & ~d;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | evt;
            samp.push_back(GPIO_In);
            void'(samp.pop_front());
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_addr(input logic [2:0] off);
        logic [31:0] a;
        a      = $urandom;
        a[4:2] = off;
        Address = a;
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        logic [31:0] r;
        r = $urandom;
        set_addr(off);
        DataIn  = {r[31:8], d};
        Select  = 1'b1;
        WriteEn = 1'b1;
        tick();
        Select  = 1'b0;
        WriteEn = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off);
        set_addr(off);
        Select  = 1'b1;
        WriteEn = 1'b0;
        tick();
        Select  = 1'b0;
    endtask

    task automatic rd_lit(input logic [2:0] off, input logic [31:0] v);
        set_addr(off);
        Select  = 1'b1;
        WriteEn = 1'b0;
        push(0, v);
        tick();
        Select  = 1'b0;
    endtask

    task automatic lit_outs(input logic [7:0] o, input logic [7:0] oe, input logic q);
        push(1, {24'h0, o});
        push(2, {24'h0, oe});
        push(3, {31'h0, q});
    endtask

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        string       nm;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                0:       begin act = DataOut;            nm = "DataOut";  end
                1:       begin act = {24'h0, GPIO_Out};  nm = "GPIO_Out"; end
                2:       begin act = {24'h0, GPIO_OE};   nm = "GPIO_OE";  end
                default: begin act = {31'h0, irq};       nm = "irq";      end
            endcase
            checks++;
            if (act !== e.exp)
                $display("FAIL %s cyc=%0d actual=%h required=%h", nm, e.cyc, act, e.exp);
            else
                passed++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        rst = 1'b0; Select = 1'b0; WriteEn = 1'b0;
        Address = 32'h0; DataIn = 32'h0; GPIO_In = 8'hFF;
        model_clear();
        @(posedge clk); #1;

        // reset held, pins high, a write attempt must be ignored
        lit_outs(8'h00, 8'h00, 1'b0);
        tick();
        wr(3'd0, 8'hFF);
        lit_outs(8'h00, 8'h00, 1'b0);
        tick();
        rst = 1'b1;
        idle(2);
        rd_lit(3'd1, 32'h0000_00FF);

        // output register, set/clear aliases
        wr(3'd0, 8'hA5);
        wr(3'd2, 8'hF0);
        wr(3'd6, 8'h03);
        wr(3'd7, 8'h80);
        lit_outs(8'h27, 8'hF0, 1'b0);
        rd_lit(3'd6, 32'h0);
        rd_lit(3'd7, 32'h0);
        rd_lit(3'd0, 32'h27);
        wr(3'd1, 8'h5A);
        rd_lit(3'd2, 32'hF0);

        // rising edge on pin 0, irq exactly three edges after sampling
        GPIO_In = 8'h00;
        idle(4);
        wr(3'd5, 8'h00);
        wr(3'd3, 8'h01);
        GPIO_In = 8'h01;
        push(3, 32'h0); tick();
        push(3, 32'h0); tick();
        push(3, 32'h0); tick();
        push(3, 32'h1);
        rd_lit(3'd4, 32'h01);
        wr(3'd4, 8'h01);
        push(3, 32'h0); tick();

        // falling-edge polarity on pin 1; rising edge ignored
        wr(3'd5, 8'h02);
        wr(3'd3, 8'h02);
        GPIO_In = 8'h03;
        idle(4);
        rd_lit(3'd4, 32'h00);
        GPIO_In = 8'h01;
        idle(3);
        rd_lit(3'd4, 32'h02);
        wr(3'd4, 8'h02);
        GPIO_In = 8'h03;
        idle(4);
        rd_lit(3'd4, 32'h00);

        // event and write-1-clear on the same edge: bit stays set
        GPIO_In = 8'h01;
        idle(3);
        GPIO_In = 8'h03;
        idle(4);
        GPIO_In = 8'h01;
        tick();
        tick();
        wr(3'd4, 8'h02);
        push(3, 32'h1);
        rd_lit(3'd4, 32'h02);

        // disabling the enable masks irq but keeps status
        wr(3'd4, 8'hFF);
        wr(3'd5, 8'h00);
        wr(3'd3, 8'h01);
        GPIO_In = 8'h00;
        idle(4);
        GPIO_In = 8'h01;
        idle(4);
        push(3, 32'h1); tick();
        wr(3'd3, 8'h00);
        push(3, 32'h0);
        rd_lit(3'd4, 32'h01);
        set_addr(3'd4);
        Select = 1'b0;
        push(0, 32'h0);
        tick();

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) GPIO_In = 8'($urandom);
            if (i == 200) begin
                rst = 1'b0;
                model_clear();
                lit_outs(8'h00, 8'h00, 1'b0);
                tick();
                wr(3'($urandom), 8'($urandom));
                rst = 1'b1;
                idle(3);
                rd_lit(3'd4, 32'h0);
                rd_lit(3'd0, 32'h0);
            end
            op = $urandom_range(0, 2);
            if (op == 0)      tick();
            else if (op == 1) rd(3'($urandom));
            else              wr(3'($urandom), 8'($urandom));
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
